// File: rtl/sevenseg_display_mux_if.sv
// Display-side signal bundle for sevenseg_display_mux: the value/mode inputs
// from the status logic and the segment/anode pins toward the board.
interface sevenseg_display_mux_if;
   logic        SW7;
   logic [15:0] current_num;
   logic [6:0]  SEG;
   logic [3:0]  AN;

   modport master (output SW7, current_num, input SEG, AN);
   modport slave  (input SW7, current_num, output SEG, AN);
endinterface

// File: rtl/sevenseg_display_mux.sv
// 4-digit common-anode seven-segment multiplexer, hex or double-dabble decimal.
// Optional macro SEVENSEG_LEADING_ZERO_BLANK_EN blanks leading decimal zeros.
module sevenseg_display_mux #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   sevenseg_display_mux_if.slave disp
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] refresh_cnt;
   logic [1:0]       digit_idx;
   logic             sample_dec;
   logic [15:0]      sample;
   logic [4:0]       bit_cnt;
   logic [19:0]      bcd, bcd_next;
   logic [15:0]      disp_reg;
   logic             overflow;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
   logic             disp_dec;
`endif

   function automatic logic [6:0] seg_code(input logic [3:0] n);
      case (n)
         4'h0: seg_code = 7'h40;  4'h1: seg_code = 7'h79;
         4'h2: seg_code = 7'h24;  4'h3: seg_code = 7'h30;
         4'h4: seg_code = 7'h19;  4'h5: seg_code = 7'h12;
         4'h6: seg_code = 7'h02;  4'h7: seg_code = 7'h78;
         4'h8: seg_code = 7'h00;  4'h9: seg_code = 7'h10;
         4'hA: seg_code = 7'h08;  4'hB: seg_code = 7'h03;
         4'hC: seg_code = 7'h46;  4'hD: seg_code = 7'h21;
         4'hE: seg_code = 7'h06;  default: seg_code = 7'h0E;
      endcase
   endfunction

   // Refresh timing: digit index advances once per REFRESH_DIV cycles.
   // NOTE: async reset in the sensitivity list; all state uses <= so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = disp.SW7 ? S_SHIFT : S_COMMIT;
         S_SHIFT:  if (bit_cnt == 5'd1) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // One double-dabble step: add-3 correction on each nibble, then shift in the sample MSB.
   always_comb begin
      logic [19:0] adj;
      adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_next = (adj << 1) | {19'd0, sample[15]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_dec <= 1'b0;
         sample     <= '0;
         bit_cnt    <= '0;
         bcd        <= '0;
         disp_reg   <= '0;
         overflow   <= 1'b0;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
         disp_dec   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               sample_dec <= disp.SW7;
               sample     <= disp.current_num;
               bit_cnt    <= 5'd16;
               bcd        <= '0;
            end
            S_SHIFT: begin
               bcd     <= bcd_next;
               sample  <= sample << 1;
               bit_cnt <= bit_cnt - 5'd1;
            end
            S_COMMIT: begin
               // Display register and overflow change together so no frame mixes results.
               disp_reg <= sample_dec ? bcd[15:0] : sample;
               overflow <= sample_dec && (bcd[19:16] != 4'd0);
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
               disp_dec <= sample_dec;
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      seg_d = seg_code(disp_reg[{digit_idx, 2'b00} +: 4]);
      if (overflow) seg_d = 7'h3F;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      else if (disp_dec &&
               ((digit_idx == 2'd3 && disp_reg[15:12] == 4'd0) ||
                (digit_idx == 2'd2 && disp_reg[15:8]  == 8'd0) ||
                (digit_idx == 2'd1 && disp_reg[15:4]  == 12'd0)))
         seg_d = 7'h7F;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= 7'h7F;
         an_q  <= 4'hF;
      end else begin
         seg_q <= seg_d;
         an_q  <= ~(4'b0001 << digit_idx);
      end
   end

   assign disp.SEG = seg_q;
   assign disp.AN  = an_q;

endmodule

// File: tb/tb_sevenseg_display_mux.sv
// Self-checking bench for sevenseg_display_mux with a short refresh period.
module tb_sevenseg_display_mux;

   localparam int RD = 4;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sevenseg_display_mux_if dif ();

   sevenseg_display_mux #(.REFRESH_DIV(RD)) dut (
      .clk   (clk),
      .reset (reset),
      .disp  (dif)
   );

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   typedef struct {
      string           name;
      logic            sw7;
      logic [15:0]     num;
      logic [3:0][6:0] seg;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input string name, input logic sw7, input logic [15:0] num,
                               input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0);
      vec_t v;
      v.name = name;
      v.sw7  = sw7;
      v.num  = num;
      v.seg  = {s3, s2, s1, s0};
      return v;
   endfunction

   // Holds reset for two cycles, releasing on a falling edge; next rising edge is the first capture.
   task automatic do_reset(input logic sw7, input logic [15:0] num);
      reset = 1'b1;
      dif.SW7 = sw7;
      dif.current_num = num;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      dif.SW7 = 1'b0;
      dif.current_num = 16'h0000;

      vecs.push_back(mk("hex_3A7F", 1'b0, 16'h3A7F, 7'h30, 7'h08, 7'h78, 7'h0E));
      vecs.push_back(mk("hex_BCDE", 1'b0, 16'hBCDE, 7'h03, 7'h46, 7'h21, 7'h06));
      vecs.push_back(mk("hex_1289", 1'b0, 16'h1289, 7'h79, 7'h24, 7'h00, 7'h10));
      vecs.push_back(mk("hex_0000", 1'b0, 16'h0000, 7'h40, 7'h40, 7'h40, 7'h40));
      vecs.push_back(mk("dec_1000", 1'b1, 16'd1000, 7'h79, 7'h40, 7'h40, 7'h40));
      vecs.push_back(mk("dec_4567", 1'b1, 16'd4567, 7'h19, 7'h12, 7'h02, 7'h78));
      vecs.push_back(mk("dec_9999", 1'b1, 16'd9999, 7'h10, 7'h10, 7'h10, 7'h10));
      vecs.push_back(mk("dec_10000", 1'b1, 16'd10000, 7'h3F, 7'h3F, 7'h3F, 7'h3F));
      vecs.push_back(mk("dec_65535", 1'b1, 16'd65535, 7'h3F, 7'h3F, 7'h3F, 7'h3F));
      vecs.push_back(mk("dec_42", 1'b1, 16'd42, LZ, LZ, 7'h19, 7'h24));
      vecs.push_back(mk("dec_0", 1'b1, 16'd0, LZ, LZ, LZ, 7'h40));

      // Asynchronous reset mid-frame, then the anode walk every RD cycles.
      do_reset(1'b0, 16'h3A7F);
      repeat (7) @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("async_reset_an", {12'd0, dif.AN}, 16'h000F);
      check("async_reset_seg", {9'd0, dif.SEG}, 16'h007F);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 4 * RD; k++) begin
         logic [3:0] exp_an;
         @(negedge clk);
         exp_an = ~(4'b0001 << ((k - 1) / RD));
         check($sformatf("an_walk_%0d", k), {12'd0, dif.AN}, {12'd0, exp_an});
         if (k == 1) check("hex_lat_before", dut.disp_reg, 16'h0000);
         if (k == 2) check("hex_lat_commit", dut.disp_reg, 16'h3A7F);
      end

      // Decimal latency: capture on edge 1, display register lands on edge 18.
      do_reset(1'b1, 16'd1000);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         check($sformatf("dec_lat_%0d", k), dut.disp_reg, (k >= 18) ? 16'h1000 : 16'h0000);
      end

      // Input change during SHIFT is ignored until the next capture.
      do_reset(1'b1, 16'd987);
      for (int k = 1; k <= 40; k++) begin
         logic [15:0] exp_disp;
         @(negedge clk);
         if (k == 5) dif.current_num = 16'd654;
         exp_disp = (k < 18) ? 16'h0000 : (k < 36) ? 16'h0987 : 16'h0654;
         check($sformatf("shift_change_%0d", k), dut.disp_reg, exp_disp);
      end

      // Table-driven frames through the scoreboard.
      foreach (vecs[i]) begin
         int t;
         @(negedge clk);
         dif.SW7 = vecs[i].sw7;
         dif.current_num = vecs[i].num;
         for (int d = 0; d < 4; d++) begin
            exp_t e;
            e.an  = ~(4'b0001 << d);
            e.seg = vecs[i].seg[d];
            sb.push_back(e);
         end
         repeat (40) @(negedge clk);
         t = 0;
         while (dif.AN !== 4'b1110 && t < 4 * RD + 2) begin
            @(negedge clk);
            t++;
         end
         for (int d = 0; d < 4; d++) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s_an%0d", vecs[i].name, d), {12'd0, dif.AN}, {12'd0, e.an});
            check($sformatf("%s_seg%0d", vecs[i].name, d), {9'd0, dif.SEG}, {9'd0, e.seg});
            repeat (RD) @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sevenseg_display_mux.md
Name: sevenseg_display_mux

Overview:
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display from a 16-bit value.
- SW7 selects the display mode: 0 = hexadecimal, 1 = decimal.
- Decimal mode uses a sequential double-dabble binary-to-BCD engine.
- Sits between the motor/status logic that supplies current_num and the board display pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays enabled. At 100 MHz this gives a 1 kHz digit rate, 250 Hz full frame. Minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- SW7  input  1  mode select: 0 = hex, 1 = decimal.
- current_num  input  16  unsigned value to display.
- SEG  output  7  segment cathodes, active-low. Bit order {g,f,e,d,c,b,a}, so SEG[0]=a.
- AN  output  4  digit anodes, active-low. AN[0] = rightmost, least-significant digit.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - AN=4'b1111 and SEG=7'b1111111 (display dark).
  - Refresh counter = 0, digit index = 0.
  - Engine state = IDLE.
  - Display register = 16'h0000, overflow flag = 0.
- Reset may assert at any time, including mid-conversion; the result is the same full reset.
- Refresh counter: counts 0..REFRESH_DIV-1. On wrap, digit index increments 0→1→2→3→0.
- AN and SEG are registered, one cycle behind the digit index and display register.
  - AN: exactly one bit low, AN[idx]=0. Never two digits enabled together.
- Conversion engine is a 3-state FSM:
  - IDLE: capture SW7 and current_num into a sample register.
    - Hex sample → COMMIT.
    - Decimal sample → SHIFT with bit counter = 16.
  - SHIFT: one double-dabble iteration per cycle over a 20-bit BCD scratch (5 digits).
    - Add 3 to each BCD nibble ≥5, then shift left one bit, taking the next sample MSB.
    - After 16 iterations → COMMIT.
  - COMMIT: update the display register and overflow flag in a single cycle (atomic), then → IDLE.
- Latency from capture to display-register update:
  - Hex: 2 cycles.
  - Decimal: 18 cycles.
- The engine reconverts continuously. Input changes during SHIFT are ignored until the next IDLE capture.
- Hex mode: display digit n = current_num[4n+3:4n]. All 16 values display as 0-9, A, b, C, d, E, F.
- Decimal mode:
  - Values 0..9999 show as four BCD digits with leading zeros.
  - Values 10000..65535 set the overflow flag; all four digits show dash (SEG=7'b0111111).
- Segment codes, active-low {g..a}, in hex:
  - 0-7 = 40, 79, 24, 30, 19, 12, 02, 78
  - 8-F = 00, 10, 08, 03, 46, 21, 06, 0E
- A mode switch takes effect at the next capture. There is no blanking during the switch.

Optional Feature:
- Macro: SEVENSEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - In decimal mode, most-significant zero digits are blanked (SEG=7'b1111111, anode still cycles).
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Hex mode and overflow dashes are unaffected.
- When undefined: all four digits are always shown with leading zeros.

Test Plan:
- Reset asserted mid-frame with REFRESH_DIV=4 → AN=1111 and SEG=1111111 immediately (asynchronous). After release, AN steps 1110→1101→1011→0111 every 4 cycles.
- SW7=0, current_num=16'h3A7F, REFRESH_DIV=4 → per digit:
  - AN=1110: SEG=0E (F)
  - AN=1101: SEG=78 (7)
  - AN=1011: SEG=08 (A)
  - AN=0111: SEG=30 (3)
- SW7=1, current_num=1000 → digits 0, 0, 0, 1 from AN[0] up, i.e. SEG 40, 40, 40, 79. Display register updates exactly 18 cycles after the capture cycle.
- SW7=1, current_num=10000 and 65535 → all digits SEG=3F (dash). current_num=9999 → all digits SEG=10 (9).
- current_num changed during SHIFT (987→654 on cycle 5 of conversion) → display shows 0987 first, then 0654 after the next conversion completes. No mixed digits at any cycle.
- With SEVENSEG_LEADING_ZERO_BLANK_EN, SW7=1, current_num=42 → AN[3:2] digits SEG=7F (blank), AN[1]=19 (4), AN[0]=24 (2). current_num=0 → only digit 0 lit, SEG=40.
